sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Memory responder for the core's load/store bus (addr, read, write, size). It replaces the ideal single-cycle SRAM model with a timed controller.
- Drives two 16-bit asynchronous SRAM chips (sram1 = data[31:16], sram2 = data[15:0]) with per-byte lane strobes and programmable wait states.
- Returns a ready handshake to the core.
- Sits between rv_core and the board SRAMs.

Parameters:
- WAIT_CYCLES, 1, number of cycles oe_l/we_l are held asserted (1..15).
- ADDR_W, 20, core byte-address width; the SRAM word address is ADDR_W-2 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_l  in  1  asynchronous active-low reset.
- addr  in  20  core byte address.
- wdata  in  32  store data, right-justified.
- rdata  out  32  load data, right-justified, zero-extended.
- read  in  1  load request, held until ready.
- write  in  1  store request, held until ready.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- ready  out  1  one-cycle pulse: access complete.
- err  out  1  one-cycle pulse with ready: misaligned address or size=11.
- sram_addr  out  18  word address = addr[19:2].
- sram_data  inout  32  SRAM data bus; tri-stated except during writes.
- oe_l, we_l  out  1 each  shared output enable and write enable.
- ce1_l, ce2_l  out  1 each  chip enables.
- ub1_l, lb1_l, ub2_l, lb2_l  out  1 each  byte-lane enables (ub1=byte3, lb1=byte2, ub2=byte1, lb2=byte0; little-endian).

Behaviour:
- Reset, asynchronous, takes effect immediately even mid-access:
  - State goes to IDLE; ready=0, err=0, rdata=0.
  - oe_l, we_l, ce*_l and all lane enables go to 1; sram_data goes to Z; sram_addr=0.
- IDLE:
  - Samples read/write every cycle. If both are asserted, write wins.
  - Request latched (addr, size, wdata, type) -> SETUP.
- SETUP (1 cycle):
  - Drive sram_addr, ce*_l and lane enables for the selected lanes. Only chips with an enabled lane get ce low.
  - Writes drive sram_data with lane-replicated wdata: byte to all 4 lanes, half to both halves.
  - Next state ACCESS; wait counter loads WAIT_CYCLES.
- ACCESS (WAIT_CYCLES cycles): oe_l=0 for reads, we_l=0 for writes. Counter decrements and leaves ACCESS at 1.
  - Read: on the final cycle, capture sram_data, shift the selected lanes down, zero-extend into rdata -> DONE.
  - Write: -> HOLD.
- HOLD (writes only, 1 cycle): we_l=1 while data, address and enables remain driven (hold time) -> DONE.
- DONE (1 cycle):
  - ready=1; all strobes deasserted; sram_data Z.
  - rdata holds its value until the next read completes.
  - Next state is IDLE. The core deasserts its request in the same cycle it sees ready, so no re-trigger occurs.
- Latency:
  - Read: request sampled in IDLE, ready 2+WAIT_CYCLES cycles later. With WAIT_CYCLES=1, ready is asserted 3 cycles after the request is sampled.
  - Write: 3+WAIT_CYCLES.
- Alignment:
  - Half requires addr[0]=0. Word requires addr[1:0]=0. size=11 is always an error.
  - Behaviour on an error is given under Optional Feature.
- Request dropped mid-access (read/write deasserted before ready): the access completes anyway and ready still pulses.

Optional Feature:
- SRAM_CTRL_ALIGN_CHECK_EN
- Defined: a misaligned or size=11 request skips SETUP/ACCESS and goes IDLE->DONE with ready=1, err=1. No SRAM strobe toggles, and rdata is unchanged.
- Undefined:
  - err is tied 0.
  - Half/word ignore the low address bits (addr[0], or addr[1:0]) and access the aligned half/word. size=11 is treated as word.

Decomposition:
- Package sram_ctrl_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encodings (S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_DONE), lane-index constants.
- Sub-module sram_lane_decode (combinational): takes size and addr[1:0]. Produces the 4-bit lane enable, the misalign flag, the write replication and the read extraction/shift. It is reused by the bench scoreboard.

Test Plan:
- Word write 0xDEADBEEF to addr 0x00100, then word read, WAIT_CYCLES=1:
  - All four lane enables are low and sram_addr=0x00040.
  - Read ready arrives 3 cycles after the request is sampled; rdata=0xDEADBEEF.
- Byte write 0xA5 to addr 0x00103:
  - Only ub1_l is low; ce2_l stays high; sram_data[31:24]=0xA5.
  - A following word read returns 0xA5ADBEEF.
- Half read at addr 0x00102 after the word write: rdata=0x0000DEAD; ub1_l and lb1_l low; ub2_l and lb2_l high.
- WAIT_CYCLES=3 write:
  - we_l is low exactly 3 cycles.
  - HOLD cycle has we_l=1 with sram_data still driven.
  - ready arrives 6 cycles after the request.
- Word read at addr 0x00102 with SRAM_CTRL_ALIGN_CHECK_EN defined: ready and err assert together; oe_l never goes low; rdata is unchanged.
- Assert rst_l=0 during ACCESS of a write:
  - we_l, ce*_l and all lane enables go high in the same timestep.
  - sram_data goes Z and ready=0.
  - After release, state is IDLE and the next read completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared encodings for the SRAM controller: access sizes, FSM states and byte-lane indices.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_DONE
    } state_e;

    // Little-endian lane numbering: B3 = sram1 upper byte ... B0 = sram2 lower byte.
    localparam int unsigned LANE_B0 = 0;
    localparam int unsigned LANE_B1 = 1;
    localparam int unsigned LANE_B2 = 2;
    localparam int unsigned LANE_B3 = 3;

endpackage

// File: rtl/sram_lane_decode.sv
// Byte-lane decoder: lane enables, misalignment flag, store replication and load extraction.
module sram_lane_decode
    import sram_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic [3:0]  lanes_o,
    output logic        misalign_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o
);

    logic [31:0] byte_shift;

    always_comb begin
        lanes_o     = 4'b1111;
        misalign_o  = 1'b0;
        wdata_rep_o = wdata_i;
        rdata_ext_o = rdata_raw_i;
        byte_shift  = rdata_raw_i >> {addr_lo_i, 3'b000};
        case (size_e'(size_i))
            SZ_BYTE: begin
                lanes_o     = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
                rdata_ext_o = {24'd0, byte_shift[7:0]};
            end
            SZ_HALF: begin
                // addr[0] only matters for the error flag; the aligned half is always selected.
                lanes_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o  = addr_lo_i[0];
                wdata_rep_o = {2{wdata_i[15:0]}};
                rdata_ext_o = {16'd0, addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0]};
            end
            SZ_WORD: begin
                misalign_o = |addr_lo_i;
            end
            SZ_RSVD: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sram_ctrl.sv
// Timed load/store responder for two 16-bit async SRAMs with programmable wait states.
// Define SRAM_CTRL_ALIGN_CHECK_EN to reject misaligned / reserved-size requests with err.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              read,
    input  logic              write,
    input  logic [1:0]        size,
    output logic              ready,
    output logic              err,
    output logic [ADDR_W-3:0] sram_addr,
    inout  wire  [31:0]       sram_data,
    output logic              oe_l,
    output logic              we_l,
    output logic              ce1_l,
    output logic              ce2_l,
    output logic              ub1_l,
    output logic              lb1_l,
    output logic              ub2_l,
    output logic              lb2_l
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [1:0]  sel_size;
    logic [1:0]  sel_lo;
    logic [3:0]  lanes;
    logic        misalign;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        drive;

    // In IDLE the decoder looks at the live request so misalignment is known before latching.
    assign sel_size = (state_q == S_IDLE) ? size      : size_q;
    assign sel_lo   = (state_q == S_IDLE) ? addr[1:0] : addr_q[1:0];

    sram_lane_decode u_decode (
        .size_i      (sel_size),
        .addr_lo_i   (sel_lo),
        .wdata_i     (wdata_q),
        .rdata_raw_i (sram_data),
        .lanes_o     (lanes),
        .misalign_o  (misalign),
        .wdata_rep_o (wdata_rep),
        .rdata_ext_o (rdata_ext)
    );

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    logic err_q, err_d;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (read || write) begin
                    addr_d  = addr;
                    size_d  = size;
                    wdata_d = wdata;
                    wr_d    = write;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
                    err_d   = misalign;
                    state_d = misalign ? S_DONE : S_SETUP;
`else
                    state_d = S_SETUP;
`endif
                end
            end
            S_SETUP: begin
                cnt_d   = WAIT_LD;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd1) begin
                    if (wr_q) begin
                        state_d = S_HOLD;
                    end else begin
                        rdata_d = rdata_ext;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oe_l  = 1'b1;
        we_l  = 1'b1;
        ce1_l = 1'b1;
        ce2_l = 1'b1;
        ub1_l = 1'b1;
        lb1_l = 1'b1;
        ub2_l = 1'b1;
        lb2_l = 1'b1;
        drive = 1'b0;
        ready = 1'b0;
        if (state_q == S_SETUP || state_q == S_ACCESS || state_q == S_HOLD) begin
            ce1_l = ~(lanes[LANE_B3] | lanes[LANE_B2]);
            ce2_l = ~(lanes[LANE_B1] | lanes[LANE_B0]);
            ub1_l = ~lanes[LANE_B3];
            lb1_l = ~lanes[LANE_B2];
            ub2_l = ~lanes[LANE_B1];
            lb2_l = ~lanes[LANE_B0];
            drive = wr_q;
            if (state_q == S_ACCESS) begin
                oe_l = wr_q;
                we_l = ~wr_q;
            end
        end
        if (state_q == S_DONE) begin
            ready = 1'b1;
        end
    end

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    assign err = (state_q == S_DONE) && err_q;
`else
    assign err = 1'b0;
`endif

    assign sram_data = drive ? wdata_rep : 'z;
    assign sram_addr = addr_q[ADDR_W-1:2];
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: channel 0 uses WAIT_CYCLES=1, channel 1 uses WAIT_CYCLES=3.
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    logic [19:0] addr_a  [2];
    logic [31:0] wdata_a [2];
    logic        read_a  [2];
    logic        write_a [2];
    logic [1:0]  size_a  [2];
    logic [31:0] rdata_a [2];
    logic        ready_a [2];
    logic        err_a   [2];
    logic [17:0] saddr_a [2];
    logic [31:0] bus_a   [2];
    logic oe_a [2], we_a [2], ce1_a [2], ce2_a [2];
    logic ub1_a [2], lb1_a [2], ub2_a [2], lb2_a [2];

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int unsigned WC = (g == 0) ? 1 : 3;
        wire [31:0] bus;
        logic [31:0] mem [256];

        pullup (bus);

        sram_ctrl #(.WAIT_CYCLES(WC), .ADDR_W(20)) u_dut (
            .clk       (clk),
            .rst_l     (rst_l),
            .addr      (addr_a[g]),
            .wdata     (wdata_a[g]),
            .rdata     (rdata_a[g]),
            .read      (read_a[g]),
            .write     (write_a[g]),
            .size      (size_a[g]),
            .ready     (ready_a[g]),
            .err       (err_a[g]),
            .sram_addr (saddr_a[g]),
            .sram_data (bus),
            .oe_l      (oe_a[g]),
            .we_l      (we_a[g]),
            .ce1_l     (ce1_a[g]),
            .ce2_l     (ce2_a[g]),
            .ub1_l     (ub1_a[g]),
            .lb1_l     (lb1_a[g]),
            .ub2_l     (ub2_a[g]),
            .lb2_l     (lb2_a[g])
        );

        // Behavioural pair of SRAM chips sharing one word array.
        assign bus = (!oe_a[g] && we_a[g]) ? mem[saddr_a[g][7:0]] : 'z;
        assign bus_a[g] = bus;

        initial for (int i = 0; i < 256; i++) mem[i] = '0;

        always @(posedge clk) begin
            if (!we_a[g]) begin
                if (!ub1_a[g] && !ce1_a[g]) mem[saddr_a[g][7:0]][31:24] <= bus[31:24];
                if (!lb1_a[g] && !ce1_a[g]) mem[saddr_a[g][7:0]][23:16] <= bus[23:16];
                if (!ub2_a[g] && !ce2_a[g]) mem[saddr_a[g][7:0]][15:8]  <= bus[15:8];
                if (!lb2_a[g] && !ce2_a[g]) mem[saddr_a[g][7:0]][7:0]   <= bus[7:0];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pins(input int c);
        return {oe_a[c], we_a[c], ce1_a[c], ce2_a[c], ub1_a[c], lb1_a[c], ub2_a[c], lb2_a[c]};
    endfunction

    typedef struct {
        int unsigned ch;
        bit          wr;
        bit          both;
        logic [1:0]  size;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;   // rdata for reads, bus value while we_l low for writes
        logic [3:0]  exp_strb;   // {ub1,lb1,ub2,lb2} while the chip is selected
        logic [1:0]  exp_ce;     // {ce1,ce2}
        logic [17:0] exp_saddr;
        int unsigned exp_lat;    // clock edges from sampling edge to ready
        int unsigned exp_act;    // cycles with oe_l/we_l low
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(input int unsigned ch, input bit wr, input bit both,
                                input logic [1:0] sz, input logic [19:0] a, input logic [31:0] wd,
                                input logic [31:0] ed, input logic [3:0] st, input logic [1:0] ce,
                                input logic [17:0] sa, input int unsigned lat,
                                input int unsigned act, input bit er);
        vec_t v;
        v.ch = ch; v.wr = wr; v.both = both; v.size = sz; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_strb = st; v.exp_ce = ce; v.exp_saddr = sa;
        v.exp_lat = lat; v.exp_act = act; v.exp_err = er;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        logic [3:0]  strb_seen = 4'hF;
        logic [1:0]  ce_seen   = 2'b11;
        logic [17:0] sa_seen   = '0;
        logic [31:0] bus_seen  = '0;
        int unsigned act = 0, quiet = 0, lat = 0, exp_quiet;
        logic err_seen = 1'b0;
        bit got = 0;
        @(negedge clk);
        addr_a[v.ch]  = v.addr;
        size_a[v.ch]  = v.size;
        wdata_a[v.ch] = v.wdata;
        write_a[v.ch] = v.wr;
        read_a[v.ch]  = !v.wr || v.both;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if ({ce1_a[v.ch], ce2_a[v.ch]} != 2'b11) begin
                strb_seen &= {ub1_a[v.ch], lb1_a[v.ch], ub2_a[v.ch], lb2_a[v.ch]};
                ce_seen   &= {ce1_a[v.ch], ce2_a[v.ch]};
                sa_seen    = saddr_a[v.ch];
                if (!we_a[v.ch] || !oe_a[v.ch]) begin
                    act++;
                    if (!we_a[v.ch]) bus_seen = bus_a[v.ch];
                end else if (!v.wr || bus_a[v.ch] == v.exp_data) begin
                    quiet++;
                end
            end
            if (ready_a[v.ch]) begin
                got = 1;
                lat = k;
                err_seen = err_a[v.ch];
                read_a[v.ch]  = 1'b0;
                write_a[v.ch] = 1'b0;
            end
        end
        if (!got) begin
            read_a[v.ch]  = 1'b0;
            write_a[v.ch] = 1'b0;
        end
        // Selected-but-idle cycles: SETUP for reads, SETUP and HOLD (data still driven) for writes.
        exp_quiet = (v.exp_act == 0) ? 0 : (v.wr ? 2 : 1);
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " lanes"}, {28'd0, strb_seen}, {28'd0, v.exp_strb});
        check({tag, " chip enables"}, {30'd0, ce_seen}, {30'd0, v.exp_ce});
        check({tag, " strobe cycles"}, act, v.exp_act);
        check({tag, " setup/hold cycles"}, quiet, exp_quiet);
        check({tag, " err"}, {31'd0, err_seen}, {31'd0, v.exp_err});
        if (v.exp_act != 0) check({tag, " sram_addr"}, {14'd0, sa_seen}, {14'd0, v.exp_saddr});
        if (v.wr) check({tag, " write bus"}, bus_seen, v.exp_data);
        else      check({tag, " rdata"}, rdata_a[v.ch], v.exp_data);
        @(negedge clk);
        check({tag, " ready pulse width"}, {31'd0, ready_a[v.ch]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt [$];
        vec_t v;
        bit seen;

        rst_l = 1'b0;
        for (int c = 0; c < 2; c++) begin
            addr_a[c] = '0; wdata_a[c] = '0; read_a[c] = 1'b0; write_a[c] = 1'b0; size_a[c] = '0;
        end
        repeat (2) @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("reset pins ch%0d", c), {24'd0, pins(c)}, 32'h0000_00FF);
            check($sformatf("reset ready/err ch%0d", c), {30'd0, ready_a[c], err_a[c]}, 32'd0);
            check($sformatf("reset rdata ch%0d", c), rdata_a[c], 32'd0);
            check($sformatf("reset sram_addr ch%0d", c), {14'd0, saddr_a[c]}, 32'd0);
            check($sformatf("reset bus released ch%0d", c), bus_a[c], 32'hFFFF_FFFF);
        end
        @(negedge clk);
        rst_l = 1'b1;

        //         ch wr bo sz     addr      wdata         exp_data      strb     ce     saddr     lat act err
        vt.push_back(mk(0, 1, 0, 2'b10, 20'h00100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 2'b00, 18'h00040, 4, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b10, 20'h00100, 32'h0,        32'hDEADBEEF, 4'b0000, 2'b00, 18'h00040, 3, 1, 0));
        vt.push_back(mk(0, 1, 0, 2'b00, 20'h00103, 32'h000000A5, 32'hA5A5A5A5, 4'b0111, 2'b01, 18'h00040, 4, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b10, 20'h00100, 32'h0,        32'hA5ADBEEF, 4'b0000, 2'b00, 18'h00040, 3, 1, 0));
        vt.push_back(mk(0, 1, 0, 2'b10, 20'h00100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 2'b00, 18'h00040, 4, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b01, 20'h00102, 32'h0,        32'h0000DEAD, 4'b0011, 2'b01, 18'h00040, 3, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 20'h00101, 32'h0,        32'h000000BE, 4'b1101, 2'b10, 18'h00040, 3, 1, 0));
        vt.push_back(mk(0, 1, 0, 2'b01, 20'h00104, 32'hFFFF1234, 32'h12341234, 4'b1100, 2'b10, 18'h00041, 4, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b10, 20'h00104, 32'h0,        32'h00001234, 4'b0000, 2'b00, 18'h00041, 3, 1, 0));
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
        vt.push_back(mk(0, 0, 0, 2'b10, 20'h00102, 32'h0,        32'h00001234, 4'b1111, 2'b11, 18'h00000, 1, 0, 1));
        vt.push_back(mk(0, 0, 0, 2'b11, 20'h00100, 32'h0,        32'h00001234, 4'b1111, 2'b11, 18'h00000, 1, 0, 1));
`else
        vt.push_back(mk(0, 0, 0, 2'b10, 20'h00102, 32'h0,        32'hDEADBEEF, 4'b0000, 2'b00, 18'h00040, 3, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b11, 20'h00100, 32'h0,        32'hDEADBEEF, 4'b0000, 2'b00, 18'h00040, 3, 1, 0));
`endif
        vt.push_back(mk(0, 1, 1, 2'b00, 20'h00100, 32'h00000077, 32'h77777777, 4'b1110, 2'b10, 18'h00040, 4, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 20'h00100, 32'h0,        32'h00000077, 4'b1110, 2'b10, 18'h00040, 3, 1, 0));
        vt.push_back(mk(1, 1, 0, 2'b10, 20'h00200, 32'hCAFEF00D, 32'hCAFEF00D, 4'b0000, 2'b00, 18'h00080, 6, 3, 0));
        vt.push_back(mk(1, 0, 0, 2'b10, 20'h00200, 32'h0,        32'hCAFEF00D, 4'b0000, 2'b00, 18'h00080, 5, 3, 0));

        foreach (vt[i]) run_txn(vt[i], $sformatf("vec%0d", i));

        // Request withdrawn right after being sampled: the access still completes.
        @(negedge clk);
        addr_a[0] = 20'h00100; size_a[0] = 2'b10; read_a[0] = 1'b1;
        @(negedge clk);
        read_a[0] = 1'b0;
        seen = 0;
        for (int k = 2; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (ready_a[0]) begin
                seen = 1;
                check("dropped read latency", k, 3);
                check("dropped read rdata", rdata_a[0], 32'hDEADBE77);
            end
        end
        if (!seen) check("dropped read ready", 32'd0, 32'd1);
        @(negedge clk);
        check("dropped read no retrigger", {24'd0, pins(0)}, 32'h0000_00FF);

        // Asynchronous reset in the middle of a WAIT_CYCLES=3 write.
        @(negedge clk);
        addr_a[1] = 20'h00300; size_a[1] = 2'b10; wdata_a[1] = 32'h13579BD0; write_a[1] = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (!we_a[1]) seen = 1;
        end
        check("reset-abort reached ACCESS", {31'd0, seen}, 32'd1);
        #2 rst_l = 1'b0;
        #1;
        check("reset-abort pins", {24'd0, pins(1)}, 32'h0000_00FF);
        check("reset-abort bus released", bus_a[1], 32'hFFFF_FFFF);
        check("reset-abort ready", {31'd0, ready_a[1]}, 32'd0);
        @(negedge clk);
        write_a[1] = 1'b0;
        rst_l = 1'b1;
        v = mk(1, 0, 0, 2'b10, 20'h00200, 32'h0, 32'hCAFEF00D, 4'b0000, 2'b00, 18'h00080, 5, 3, 0);
        run_txn(v, "post-reset read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
